// File: rtl/vga_timing_gen.sv
// Raster timing generator for the line-doubled VGA path: pixel-enable divider,
// h/v counters and sync/active/strobe decode, with PAL/NTSC switched only at frame wrap.
module vga_timing_gen #(
  parameter int unsigned CW          = 10,
  parameter int unsigned DIV         = 2,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned HS_STA      = 16,
  parameter int unsigned HS_END      = 64,
  parameter int unsigned HA_STA      = 129,
  parameter int unsigned PAL_H_LAST  = 503,
  parameter int unsigned PAL_V_LAST  = 623,
  parameter int unsigned PAL_VA_END  = 569,
  parameter int unsigned PAL_VS_STA  = 580,
  parameter int unsigned PAL_VS_END  = 583,
  parameter int unsigned PAL_V_INIT  = 560,
  parameter int unsigned NTSC_H_LAST = 519,
  parameter int unsigned NTSC_V_LAST = 525,
  parameter int unsigned NTSC_VA_END = 502,
  parameter int unsigned NTSC_VS_STA = 512,
  parameter int unsigned NTSC_VS_END = 515,
  parameter int unsigned NTSC_V_INIT = 485
) (
  input  logic          clk_dot4x,
  input  logic          rst,
  input  logic          is_pal,
  output logic          o_pix_tick,
  output logic [CW-1:0] o_h_count,
  output logic [CW-1:0] o_v_count,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_mode_pal
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt, div_cnt_d;
  logic          tick_c;
  logic [CW-1:0] h_d, v_d;
  logic          mode_d, hs_d, vs_d, active_d, line_start_d, frame_start_d;
  logic [CW-1:0] h_last, v_last, va_end, vs_sta, vs_end;

  // Timing set currently in force; a pending is_pal change never reaches here mid-frame
  always_comb begin
    h_last = o_mode_pal ? CW'(PAL_H_LAST) : CW'(NTSC_H_LAST);
    v_last = o_mode_pal ? CW'(PAL_V_LAST) : CW'(NTSC_V_LAST);
    va_end = o_mode_pal ? CW'(PAL_VA_END) : CW'(NTSC_VA_END);
    vs_sta = o_mode_pal ? CW'(PAL_VS_STA) : CW'(NTSC_VS_STA);
    vs_end = o_mode_pal ? CW'(PAL_VS_END) : CW'(NTSC_VS_END);
  end

  // Next-state counters and decode; decode follows the next counters so outputs stay aligned
  always_comb begin
    tick_c        = (div_cnt == DW'(DIV - 1));
    div_cnt_d     = div_cnt + DW'(1);
    h_d           = o_h_count;
    v_d           = o_v_count;
    mode_d        = o_mode_pal;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick_c) begin
      div_cnt_d = '0;
      if (o_h_count == h_last) begin
        h_d          = '0;
        line_start_d = 1'b1;
        if (o_v_count == v_last) begin
          v_d           = '0;
          frame_start_d = 1'b1;
          mode_d        = is_pal;
        end else begin
          v_d = o_v_count + CW'(1);
        end
      end else begin
        h_d = o_h_count + CW'(1);
      end
    end
    // At the mode-switch point h = v = 0, where both sets decode identically
    hs_d     = ((h_d >= CW'(HS_STA)) && (h_d < CW'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d     = ((v_d >= vs_sta) && (v_d < vs_end)) ? VS_POL : ~VS_POL;
    active_d = (h_d >= CW'(HA_STA)) && (v_d < va_end);
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      div_cnt       <= '0;
      o_pix_tick    <= 1'b0;
      o_h_count     <= '0;
      o_v_count     <= is_pal ? CW'(PAL_V_INIT) : CW'(NTSC_V_INIT);
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_mode_pal    <= is_pal;
    end else begin
      div_cnt       <= div_cnt_d;
      o_pix_tick    <= tick_c;
      o_h_count     <= h_d;
      o_v_count     <= v_d;
      o_hs          <= hs_d;
      o_vs          <= vs_d;
      o_active      <= active_d;
      o_line_start  <= line_start_d;
      o_frame_start <= frame_start_d;
      o_mode_pal    <= mode_d;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed PAL-only VGA sync counter. Generates horizontal/vertical counters, sync, active and strobe outputs for the 2x line-doubled VGA path, clocked from clk_dot4x with a programmable pixel-enable divider. Both PAL and NTSC timing sets are held as parameters. The set in use is selected at runtime by is_pal, and a change is applied only at a frame boundary so the output raster never tears. Sits between the clock/reset block and the line-buffer scaler, which consumes o_h_count and o_pix_tick.

Parameters:
CW, 10, counter width for h/v counts
DIV, 2, clk_dot4x cycles per pixel tick (>=1)
HS_POL, 0, hsync asserted level (0 = active low)
VS_POL, 0, vsync asserted level (0 = active low)
HS_STA, 16, hsync start column (both modes)
HS_END, 64, hsync end column, exclusive (both modes)
HA_STA, 129, first active column (both modes)
PAL_H_LAST / PAL_V_LAST, 503 / 623, last column / last line, PAL
PAL_VA_END / PAL_VS_STA / PAL_VS_END, 569 / 580 / 583, active end (exclusive), vsync start, vsync end (exclusive), PAL
PAL_V_INIT, 560, v_count loaded at reset, PAL
NTSC_H_LAST / NTSC_V_LAST, 519 / 525, last column / last line, NTSC
NTSC_VA_END / NTSC_VS_STA / NTSC_VS_END, 502 / 512 / 515, as above, NTSC
NTSC_V_INIT, 485, v_count loaded at reset, NTSC

Ports:
clk_dot4x  in  1  sole clock
rst  in  1  synchronous, active-high reset
is_pal  in  1  requested timing set (1 = PAL)
o_pix_tick  out  1  one-cycle pulse; counters advance on this cycle
o_h_count  out  CW  current column
o_v_count  out  CW  current line
o_hs  out  1  horizontal sync, polarity HS_POL
o_vs  out  1  vertical sync, polarity VS_POL
o_active  out  1  high in the visible region
o_line_start  out  1  one-cycle pulse when h_count becomes 0
o_frame_start  out  1  one-cycle pulse when h_count and v_count both become 0
o_mode_pal  out  1  timing set currently in force

Behaviour:
- All outputs are registered. o_hs, o_vs and o_active are decoded from next-state counters, so they are aligned with o_h_count/o_v_count in the same cycle.
- Reset, sampled on the clk_dot4x edge:
  - div_cnt = 0, o_h_count = 0, o_pix_tick = 0.
  - o_mode_pal = is_pal.
  - o_v_count = PAL_V_INIT if is_pal, else NTSC_V_INIT.
  - o_hs = ~HS_POL, o_vs = ~VS_POL, o_active = 0.
  - o_line_start = 0, o_frame_start = 0.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - Tick condition is div_cnt == DIV-1. o_pix_tick is high the cycle the counters update.
  - DIV = 1 gives a tick every cycle.
- On each tick:
  - If h == H_LAST: h <= 0, o_line_start = 1.
    - If also v == V_LAST: v <= 0, o_frame_start = 1, and o_mode_pal <= is_pal.
    - Otherwise v <= v+1.
  - Otherwise h <= h+1.
  - H_LAST, V_LAST, VA_END, VS_STA and VS_END are taken from the set selected by o_mode_pal, not by is_pal.
- Mode change:
  - An is_pal toggle mid-frame is held pending and applied only at the frame wrap.
  - Multiple toggles within a frame collapse; only the value present at the wrap tick counts.
  - The new mode's first line is v = 0 (V_INIT is used only at reset).
- Decode, using the set in force:
  - hs asserted iff HS_STA <= h < HS_END.
  - vs asserted iff VS_STA <= v < VS_END.
  - active iff h >= HA_STA and v < VA_END.
- Strobes:
  - o_line_start and o_frame_start are high for exactly one clk_dot4x cycle, coincident with o_pix_tick.
  - Both are low on non-tick cycles.
- Counters never exceed the in-force H_LAST/V_LAST, because a mode switch happens only when both are 0.
- Reset asserted mid-line or mid-frame: the next cycle shows the reset values; the divider phase restarts.

Test Plan:
- Reset with is_pal = 1, DIV = 2 -> h = 0, v = 560, hs = 1, vs = 1, active = 0, mode_pal = 1; first o_pix_tick 2 cycles after rst deasserts; h = 1 at that tick.
- PAL free-run -> line_start period 1008 clocks; hs low for h 16..63 (96 clocks); first frame_start after 64 line wraps (v 560..623 -> 0); active high for h 129..503 on lines 0..568.
- PAL frame -> vs low on exactly lines 580, 581 and 582; next frame_start 624 lines after the previous one.
- Toggle is_pal to 0 at v = 100 -> o_mode_pal stays 1 until the frame_start tick, then 0; the next line wraps at h = 519; the frame wraps after v = 525; vs low on lines 512..514.
- Pulse is_pal 0 -> 1 -> 0 within one frame -> no mode change at the wrap.
- DIV = 1, HS_POL = 1 build -> o_pix_tick constantly high; line period 504 clocks; hs high for 48 clocks; assert rst at v = 300 -> next cycle v = V_INIT of the current is_pal, h = 0.
